// File: rtl/spi_slave.sv
// SPI slave for all four cpol/cpha modes: the SPI pins are synchronized into
// clk and full-duplex frames of DATA_W bits are exchanged MSB first.
module spi_slave #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [DATA_W-1:0] din,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              ss_n,
  output logic              miso,
  output logic [DATA_W-1:0] dout,
  output logic              done,
  output logic              busy
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] vld_q, vld_d;
  logic                   sclk_d1_q, sclk_d1_d;
  logic                   ss_d1_q, ss_d1_d;
  logic                   armed_q, armed_d;
  logic                   cpol_q, cpol_d;
  logic                   cpha_q, cpha_d;
  logic [DATA_W-1:0]      tx_q, tx_d;
  logic [DATA_W-1:0]      rx_q, rx_d;
  logic [DATA_W-1:0]      dout_q, dout_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic sclk_s, ss_s, mosi_s;
  logic sclk_rise, sclk_fall, ss_fall;
  logic lead, trail, sample, shift_out, start, last;
  logic miso_en;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d1_q;
  assign sclk_fall = ~sclk_s & sclk_d1_q;
  assign ss_fall   = ~ss_s & ss_d1_q;
  assign lead      = cpol_q ? sclk_fall : sclk_rise;
  assign trail     = cpol_q ? sclk_rise : sclk_fall;
  assign sample    = cpha_q ? trail : lead;
  // The first shift edge of a word is skipped: the MSB is already on miso.
  assign shift_out = (cpha_q ? lead : trail) & (cnt_q != '0);
  assign last      = sample & (cnt_q == CNT_W'(DATA_W - 1));
  // The reset values of the ss_n chain would look like a falling edge when
  // ss_n is held low through reset; only arm once a real high has been seen.
  assign start     = ss_fall & armed_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sclk_sync_q <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      vld_q       <= '0;
      sclk_d1_q   <= 1'b0;
      ss_d1_q     <= 1'b1;
      armed_q     <= 1'b0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      dout_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      vld_q       <= vld_d;
      sclk_d1_q   <= sclk_d1_d;
      ss_d1_q     <= ss_d1_d;
      armed_q     <= armed_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      dout_q      <= dout_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (ss_s) state_d = IDLE;
               else if (last) state_d = DONE;
      DONE:    state_d = ss_s ? IDLE : SHIFT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    vld_d       = {vld_q[SYNC_STAGES-2:0], 1'b1};
    sclk_d1_d   = sclk_s;
    ss_d1_d     = ss_s;
    armed_d     = armed_q | (vld_q[SYNC_STAGES-1] & ss_s);
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    dout_d      = dout_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          cpol_d = cpol;
          cpha_d = cpha;
          tx_d   = din;
          rx_d   = '0;
          cnt_d  = '0;
        end
      end
      SHIFT: begin
        if (ss_s) begin
          cnt_d = '0;
        end else begin
          if (sample) begin
            rx_d  = {rx_q[DATA_W-2:0], mosi_s};
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (last) dout_d = {rx_q[DATA_W-2:0], mosi_s};
          if (shift_out) tx_d = {tx_q[DATA_W-2:0], 1'b0};
        end
      end
      DONE: begin
        cnt_d = '0;
        if (!ss_s) tx_d = din;
      end
      default: cnt_d = '0;
    endcase
  end

  always_comb begin
    done    = (state_q == DONE);
    busy    = (state_q != IDLE);
    miso_en = (state_q != IDLE) & ~ss_s;
  end

  assign miso = miso_en ? tx_q[DATA_W-1] : 1'bz;
  assign dout = dout_q;

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 8, giving the frame length in bits.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth on sclk, ss_n and mosi (minimum 2).
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cpol  input  1  SPI clock idle level.
REQ-006 SHALL have port cpha  input  1  SPI clock phase.
REQ-007 SHALL have port din  input  DATA_W  transmit word, returned to the master on miso.
REQ-008 SHALL have port sclk  input  1  serial clock from the master, asynchronous to clk.
REQ-009 SHALL have port mosi  input  1  serial data from the master.
REQ-010 SHALL have port ss_n  input  1  active-low slave select.
REQ-011 SHALL have port miso  output  1  serial data to the master; high-impedance while deselected.
REQ-012 SHALL have port dout  output  DATA_W  last complete received word.
REQ-013 SHALL have port done  output  1  one-clk pulse per complete frame.
REQ-014 SHALL have port busy  output  1  high while a frame is in progress.

Function
REQ-015 SHALL pass sclk, ss_n and mosi through SYNC_STAGES flops and detect sclk and ss_n edges by comparing the synchronized value with its one-cycle-delayed copy.
REQ-016 SHALL operate correctly only when each sclk high or low phase lasts at least 4 clk periods; faster sclk is outside the operating range.
REQ-017 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-018 In IDLE, detecting the synchronized ss_n falling edge SHALL:
- latch cpol, cpha and din into internal registers;
- clear the bit counter;
- assert busy;
- move to SHIFT.
Changes on cpol, cpha or din after that point SHALL be ignored until the next frame.
REQ-019 The leading edge SHALL be the sclk rising edge when latched cpol=0 and the falling edge when cpol=1; the trailing edge SHALL be the opposite edge.
REQ-020 With cpha=0:
- MSB of the latched din SHALL drive miso within 1 clk of entering SHIFT;
- mosi SHALL be sampled on each leading edge;
- the next transmit bit SHALL be shifted out on each trailing edge.
REQ-021 With cpha=1:
- miso SHALL shift out the next bit (MSB first) on each leading edge;
- mosi SHALL be sampled on each trailing edge.
REQ-022 Data SHALL be MSB first in both directions; received bits SHALL shift into an internal register from the LSB end.
REQ-023 On the DATA_W-th sample the FSM SHALL enter DONE. In DONE, the received word SHALL transfer to dout and done SHALL be high for exactly one clk.
REQ-024 DONE SHALL last one cycle and then behave as follows:
- if ss_n is still low: reload din, clear the counter, return to SHIFT (back-to-back frame); for cpha=0 the new MSB drives miso on the next cycle;
- otherwise: go to IDLE.
REQ-025 Synchronized ss_n rising in SHIFT (abort) SHALL:
- clear the counter;
- deassert busy;
- leave dout unchanged, with no done pulse;
- return to IDLE.
REQ-026 The bit counter SHALL be ceil(log2(DATA_W+1)) bits wide and SHALL never wrap past DATA_W.
REQ-027 sclk edges seen while in IDLE SHALL be ignored.
REQ-028 miso SHALL be 1'bz whenever synchronized ss_n is high or the FSM is in IDLE.

Reset
REQ-029 reset low SHALL asynchronously force all outputs and state:
- FSM to IDLE;
- dout = 0, done = 0, busy = 0, miso = z;
- shift registers and counter to 0;
- synchronizer flops to the deselected/idle values (ss_n = 1, sclk = 0, mosi = 0).
REQ-030 Reset asserted mid-frame SHALL abort the frame with no done pulse. After reset release, an ss_n still held low SHALL NOT start a frame; only a fresh ss_n falling edge starts one.

Verification
REQ-031 Mode 0 (cpol=0, cpha=0), sclk = clk/10, master sends 0xA5, din = 0x3C -> dout = 0xA5, one done pulse, master receives 0x3C, busy falls after ss_n rises.
REQ-032 Modes 1, 2 and 3, master sends 0x5A/0xFF/0x01 with din = 0xC3/0x00/0x80 -> dout equals the sent byte and the master receives din each time.
REQ-033 Abort: mode 0, ss_n raised after 4 sclk cycles, then a full frame sending 0x81 -> no done for the aborted frame, dout = 0x81 after the second frame, and the aborted frame's bits do not leak into it.
REQ-034 Back-to-back: mode 3, ss_n held low for 16 sclk cycles, master sends 0x12 then 0x34, din changed to 0x77 before the first done -> two done pulses, dout = 0x12 then 0x34, master receives the first-frame din then 0x77.
REQ-035 Reset mid-frame after 3 bits with ss_n held low -> dout = 0, done never pulses, miso = z, and no frame starts until ss_n goes high then low again.
REQ-036 cpol toggled mid-frame in mode 0 -> the frame completes correctly using the latched mode.
